// File: rtl/expr_vector_sequencer.sv
// expr_vector_sequencer: LFSR operand generator, settle/capture sequencer and MISR signature for the expression datapath
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin a run (IDLE/DONE only), cancel a run (highest priority)
//   seed, vec_count     LFSR seed and number of vectors for the run
//   op_bus, op_valid    operand vector to the datapath and its drive qualifier
//   dut_y               datapath result, sampled in CAPTURE
//   busy, done          run in progress, run complete with valid signature
//   vec_done, signature vectors captured so far and MISR value
// Option EXPR_SEQ_RESULT_STREAM_EN adds res_valid/res_ready/res_data: each captured
// result is offered on a ready/valid stream and the run stalls until it is taken.
module expr_vector_sequencer #(
    parameter int               OPW       = 60,
    parameter int               RESW      = 90,
    parameter int               CNTW      = 16,
    parameter int               SETTLE    = 1,
    parameter logic [OPW-1:0]   LFSR_TAPS = 60'hC00000000000000,
    parameter logic [RESW-1:0]  MISR_TAPS = 90'h30000000000000000000014
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [OPW-1:0]   seed,
    input  logic [CNTW-1:0]  vec_count,
    output logic [OPW-1:0]   op_bus,
    output logic             op_valid,
    input  logic [RESW-1:0]  dut_y,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  vec_done,
    output logic [RESW-1:0]  signature
`ifdef EXPR_SEQ_RESULT_STREAM_EN
    ,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RESW-1:0]  res_data
`endif
);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] WLOAD = SW'(SETTLE > 0 ? SETTLE - 1 : 0);

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CAPTURE, RESULT, DONE} state_t;

    state_t          state, nxt;
    logic [OPW-1:0]  lfsr;
    logic [CNTW-1:0] rem;
    logic [SW-1:0]   wcnt;
    logic            launch;
    logic [OPW-1:0]  lfsr_adv;
    logic [RESW-1:0] sig_adv;

    assign launch   = (state == IDLE || state == DONE) && start;
    assign lfsr_adv = {lfsr[OPW-2:0], ^(lfsr & LFSR_TAPS)};
    assign sig_adv  = {signature[RESW-2:0], ^(signature & MISR_TAPS)} ^ dut_y;
    assign op_valid = state == DRIVE || state == WAIT || state == CAPTURE;
    assign busy     = op_valid || state == RESULT;
    assign done     = state == DONE;
`ifdef EXPR_SEQ_RESULT_STREAM_EN
    assign res_valid = state == RESULT;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = start ? (vec_count == '0 ? DONE : DRIVE) : state;
            DRIVE:      nxt = SETTLE > 0 ? WAIT : CAPTURE;
            WAIT:       nxt = wcnt == '0 ? CAPTURE : WAIT;
`ifdef EXPR_SEQ_RESULT_STREAM_EN
            CAPTURE:    nxt = RESULT;
            RESULT:     nxt = res_ready ? (rem == '0 ? DONE : DRIVE) : RESULT;
`else
            CAPTURE:    nxt = rem == CNTW'(1) ? DONE : DRIVE;
`endif
            default:    nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end

    // op_bus only changes when a new vector is launched, so it stays stable through
    // WAIT/CAPTURE (and any result stall) and keeps the last vector in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= '0;
            op_bus    <= '0;
            rem       <= '0;
            wcnt      <= '0;
            vec_done  <= '0;
            signature <= '0;
`ifdef EXPR_SEQ_RESULT_STREAM_EN
            res_data  <= '0;
`endif
        end else if (!abort) begin
            if (launch) begin
                lfsr      <= seed == '0 ? OPW'(1) : seed;
                op_bus    <= seed == '0 ? OPW'(1) : seed;
                rem       <= vec_count;
                vec_done  <= '0;
                signature <= '0;
            end
            if (state == DRIVE) wcnt <= WLOAD;
            if (state == WAIT) wcnt <= wcnt - 1'b1;
            if (state == CAPTURE) begin
                signature <= sig_adv;
                vec_done  <= &vec_done ? vec_done : vec_done + 1'b1;
                lfsr      <= lfsr_adv;
                rem       <= rem - 1'b1;
`ifdef EXPR_SEQ_RESULT_STREAM_EN
                res_data  <= dut_y;
`else
                if (rem != CNTW'(1)) op_bus <= lfsr_adv;
`endif
            end
`ifdef EXPR_SEQ_RESULT_STREAM_EN
            if (state == RESULT && res_ready && rem != '0) op_bus <= lfsr;
`endif
        end
    end
endmodule

// File: tb/tb_expr_vector_sequencer.sv
// tb_expr_vector_sequencer: randomized self-checking bench with a behavioural LFSR/MISR model
module tb_expr_vector_sequencer;
    localparam int OPW = 60, RESW = 90, CNTW = 16, SETTLE = 1;
`ifdef EXPR_SEQ_RESULT_STREAM_EN
    localparam int PER = SETTLE + 3;
`else
    localparam int PER = SETTLE + 2;
`endif

    logic clk = 0, rst_n = 0, start = 0, abort = 0;
    logic [OPW-1:0] seed = '0, op_bus;
    logic [CNTW-1:0] vec_count = '0, vec_done;
    logic [RESW-1:0] dut_y, signature, yconst = '0;
    logic op_valid, busy, done, ymode = 0, seen_busy = 0;
    int checks = 0, errors = 0;
`ifdef EXPR_SEQ_RESULT_STREAM_EN
    logic res_valid, res_ready = 1;
    logic [RESW-1:0] res_data;
`endif

    expr_vector_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
        .vec_count(vec_count), .op_bus(op_bus), .op_valid(op_valid), .dut_y(dut_y),
        .busy(busy), .done(done), .vec_done(vec_done), .signature(signature)
`ifdef EXPR_SEQ_RESULT_STREAM_EN
        , .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`endif
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (busy) seen_busy = 1;

    function automatic logic [RESW-1:0] fy(input logic [OPW-1:0] v);
        return {v[29:0], ~v};
    endfunction

    assign dut_y = ymode ? fy(op_bus) : yconst;

    function automatic logic [RESW-1:0] model(input logic [OPW-1:0] s, input int n,
                                              output logic [OPW-1:0] last);
        logic [OPW-1:0] v;
        logic [RESW-1:0] sg, y;
        v = (s == 0) ? OPW'(1) : s;
        sg = '0;
        last = v;
        for (int i = 0; i < n; i++) begin
            y = ymode ? fy(v) : yconst;
            sg = {sg[RESW-2:0], sg[89] ^ sg[88] ^ sg[4] ^ sg[2]} ^ y;
            last = v;
            v = {v[OPW-2:0], v[59] ^ v[58]};
        end
        return sg;
    endfunction

    function automatic logic [OPW-1:0] rnd_seed();
        return {$urandom(), $urandom()};
    endfunction

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [OPW-1:0] s, input int n, input bit noise, output int edges);
        seed = s;
        vec_count = CNTW'(n);
        start = 1;
        edges = 0;
        for (int i = 0; i < n * PER + 10; i++) begin
            step(1);
            edges++;
            if (done) break;
            start = noise && edges == 1;
            if (start) seed = rnd_seed();
        end
        start = 0;
    endtask

    task automatic test_reset();
        int e;
        rst_n = 0;
        #12;
        checks++;
        if ({op_bus, op_valid, busy, done, vec_done, signature} !== '0) begin
            errors++;
            $display("FAIL reset_state: op_bus=%h op_valid=%b busy=%b done=%b vec_done=%0d sig=%h, want all 0",
                     op_bus, op_valid, busy, done, vec_done, signature);
        end
        @(negedge clk) rst_n = 1;
        ymode = 1;
        seed = rnd_seed();
        vec_count = 5;
        start = 1;
        step(1);
        start = 0;
        step(4);
        checks++;
        if (busy !== 1 || vec_done !== 1) begin
            errors++;
            $display("FAIL pre_reset_run: busy=%b vec_done=%0d, want 1/1", busy, vec_done);
        end
        rst_n = 0;
        #2;
        checks++;
        if ({op_bus, op_valid, busy, done, vec_done, signature} !== '0) begin
            errors++;
            $display("FAIL async_reset: op_bus=%h op_valid=%b busy=%b done=%b vec_done=%0d sig=%h, want all 0",
                     op_bus, op_valid, busy, done, vec_done, signature);
        end
        @(negedge clk) rst_n = 1;
        step(2);
        checks++;
        if (busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0/0", busy, done);
        end
        e = 0;
    endtask

    task automatic test_single();
        logic [OPW-1:0] last;
        logic [RESW-1:0] exp;
        ymode = 0;
        yconst = 90'h5;
        seed = 1;
        vec_count = 1;
        exp = model(1, 1, last);
        start = 1;
        step(1);
        start = 0;
        checks++;
        if (op_bus !== 1 || op_valid !== 1 || busy !== 1) begin
            errors++;
            $display("FAIL single_drive: op_bus=%h valid=%b busy=%b, want 1/1/1", op_bus, op_valid, busy);
        end
        step(PER - 1);
        checks++;
        if (done !== 0) begin
            errors++;
            $display("FAIL single_early_done: done=%b, want 0", done);
        end
        step(1);
        checks++;
        if (done !== 1 || signature !== exp || vec_done !== 1 || busy !== 0) begin
            errors++;
            $display("FAIL single_done: done=%b sig=%h vec_done=%0d busy=%b, want 1/%h/1/0",
                     done, signature, vec_done, busy, exp);
        end
    endtask

    task automatic test_two();
        logic [OPW-1:0] last;
        logic [RESW-1:0] exp;
        int e;
        ymode = 0;
        yconst = 90'h5;
        exp = model(1, 2, last);
        run(1, 2, 0, e);
        checks++;
        if (e !== 2 * PER + 1 || signature !== exp || vec_done !== 2 || op_bus !== last) begin
            errors++;
            $display("FAIL two_vectors: edges=%0d sig=%h vec_done=%0d op_bus=%h, want %0d/%h/2/%h",
                     e, signature, vec_done, op_bus, 2 * PER + 1, exp, last);
        end
    endtask

    task automatic test_zero();
        int e;
        seen_busy = 0;
        run(rnd_seed(), 0, 0, e);
        checks++;
        if (e !== 1 || done !== 1 || signature !== '0 || vec_done !== 0 || seen_busy !== 0) begin
            errors++;
            $display("FAIL zero_count: edges=%0d done=%b sig=%h vec_done=%0d seen_busy=%b, want 1/1/0/0/0",
                     e, done, signature, vec_done, seen_busy);
        end
        seed = 0;
        vec_count = 1;
        start = 1;
        step(1);
        start = 0;
        checks++;
        if (op_bus !== 1 || op_valid !== 1) begin
            errors++;
            $display("FAIL zero_seed: op_bus=%h valid=%b, want 1/1", op_bus, op_valid);
        end
        step(PER);
    endtask

    task automatic test_random();
        logic [OPW-1:0] s, last;
        logic [RESW-1:0] exp;
        int n, e;
        bit noise;
        ymode = 1;
        for (int it = 0; it < 10; it++) begin
            s = it == 0 ? '0 : rnd_seed();
            n = $urandom_range(1, 12);
            noise = 1'($urandom_range(0, 1));
            exp = model(s, n, last);
            run(s, n, noise, e);
            checks++;
            if (e !== n * PER + 1 || done !== 1 || signature !== exp || vec_done !== CNTW'(n) || op_bus !== last) begin
                errors++;
                $display("FAIL random_run%0d: edges=%0d done=%b sig=%h vec_done=%0d op_bus=%h, want %0d/1/%h/%0d/%h",
                         it, e, done, signature, vec_done, op_bus, n * PER + 1, exp, n, last);
            end
        end
    endtask

    task automatic test_abort();
        logic [OPW-1:0] s, last;
        logic [RESW-1:0] exp;
        int e;
        ymode = 1;
        s = rnd_seed();
        exp = model(s, 1, last);
        seed = s;
        vec_count = 4;
        start = 1;
        step(1);
        start = 0;
        step(PER + 1);
        abort = 1;
        start = 1;
        step(1);
        abort = 0;
        start = 0;
        checks++;
        if (busy !== 0 || done !== 0 || op_valid !== 0 || vec_done !== 1 || signature !== exp) begin
            errors++;
            $display("FAIL abort_mid: busy=%b done=%b valid=%b vec_done=%0d sig=%h, want 0/0/0/1/%h",
                     busy, done, op_valid, vec_done, signature, exp);
        end
        step(3);
        checks++;
        if (busy !== 0 || vec_done !== 1) begin
            errors++;
            $display("FAIL abort_hold: busy=%b vec_done=%0d, want 0/1", busy, vec_done);
        end
        run(rnd_seed(), 1, 0, e);
        abort = 1;
        step(1);
        abort = 0;
        checks++;
        if (done !== 0 || vec_done !== 1) begin
            errors++;
            $display("FAIL abort_done: done=%b vec_done=%0d, want 0/1", done, vec_done);
        end
    endtask

`ifdef EXPR_SEQ_RESULT_STREAM_EN
    task automatic test_stream();
        logic [OPW-1:0] s, last, ob;
        logic [RESW-1:0] exp, rd;
        int e;
        ymode = 1;
        s = rnd_seed();
        exp = model(s, 2, last);
        res_ready = 0;
        seed = s;
        vec_count = 2;
        start = 1;
        step(1);
        start = 0;
        e = 0;
        while (!res_valid && e < 20) begin
            step(1);
            e++;
        end
        rd = res_data;
        ob = op_bus;
        checks++;
        if (res_valid !== 1 || rd !== fy(s)) begin
            errors++;
            $display("FAIL stream_first: valid=%b data=%h, want 1/%h", res_valid, rd, fy(s));
        end
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++;
            if (res_valid !== 1 || res_data !== rd || op_bus !== ob) begin
                errors++;
                $display("FAIL stream_stall%0d: valid=%b data=%h op_bus=%h, want 1/%h/%h",
                         i, res_valid, res_data, op_bus, rd, ob);
            end
        end
        res_ready = 1;
        e = 0;
        while (!done && e < 20) begin
            step(1);
            e++;
        end
        checks++;
        if (done !== 1 || signature !== exp || vec_done !== 2) begin
            errors++;
            $display("FAIL stream_done: done=%b sig=%h vec_done=%0d, want 1/%h/2", done, signature, vec_done, exp);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_two();
        test_zero();
        test_random();
        test_abort();
`ifdef EXPR_SEQ_RESULT_STREAM_EN
        test_stream();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
